fib_job_arbiter: RTL
====================

# fib_job_arbiter

Controller that owns the Fibonacci term generator and shares it between two requesters. Each requester asks for a job of N terms. The block arbitrates round-robin, restarts the generator from 0,1 for the granted job, and streams the terms out over a valid/ready interface tagged with the requester ID. It also flags arithmetic wrap-around and marks the last term. It sits between client logic and the shared output/display path.

## Interface
- W, 8, term width in bits
- CW, 4, job-length field width; a length of 0 encodes 2^CW terms
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  2  per-client job request; level-sensitive, sampled only in IDLE
- len0  in  CW  job length for client 0, latched at grant
- len1  in  CW  job length for client 1, latched at grant
- gnt  out  2  one-hot grant, held for the whole job
- busy  out  1  high while a job is active
- out_valid  out  1  term available
- out_ready  in  1  consumer accepts term
- out_data  out  W  current term
- out_id  out  1  client owning the current job
- out_last  out  1  current term is the final term of the job
- out_ovf  out  1  current term, or an earlier term in this job, came from a truncated sum

## Operation
- States: IDLE, STREAM.
- Internal registers:
  - prev, curr (W bits)
  - prev_ovf, curr_ovf (sticky)
  - rem (CW+1 bits)
  - rr (1-bit priority pointer)
- Reset (async, any state): state=IDLE, prev=0, curr=1, ovf bits=0, rem=0, rr=0. All outputs are 0.
- IDLE:
  - If req==00, stay in IDLE.
  - If exactly one req bit is set, grant that client.
  - If req==11, grant client rr.
  - On grant:
    - gnt=onehot(k), out_id=k, busy=1.
    - prev=0, curr=1, ovf bits=0.
    - rem=len_k, or 2^CW if len_k==0.
    - Go to STREAM.
- STREAM:
  - out_valid=1, out_data=prev, out_ovf=prev_ovf, out_last=(rem==1).
  - A handshake is out_valid & out_ready.
  - On a handshake that is not the last term:
    - prev<=curr
    - {c,curr}<=curr+prev (W+1-bit sum, low W bits kept)
    - prev_ovf<=curr_ovf
    - curr_ovf<=c|curr_ovf|prev_ovf
    - rem<=rem-1
  - On the handshake of the last term:
    - Go to IDLE.
    - gnt=0, busy=0, out_valid=0, out_last=0.
    - rr<=~out_id, so the other client gets priority next.
  - With no handshake, all outputs and registers hold. Data is stable while valid is high and ready is low.
- req is ignored while in STREAM. Dropping req mid-job does not abort the job; the job always runs to completion.
- len0/len1 changes after grant have no effect.
- A zero-valued term is legal data; the first term of every job is 0.

## Timing
- All outputs are registered; there is no combinational path from req/out_ready to any output.
- Grant latency: req sampled high in IDLE at edge t → gnt, busy and out_valid high after edge t.
- Throughput: one term per cycle while out_ready=1.
- Inter-job gap: the last handshake at edge t gives IDLE for one cycle; the earliest next grant is at edge t+1. This is exactly one bubble cycle with out_valid=0.
- Back-to-back, both clients requesting continuously: jobs alternate 0,1,0,1…
- Reset asserted mid-job: outputs are 0 immediately (async). After deassertion the block is in IDLE with rr=0, and the first edge with req≠0 grants.

## Test plan
- Single-job sequence:
  - Stimulus: reset, then req=01, len0=6, out_ready=1.
  - Response: gnt=01 one cycle after req. out_data = 0,1,1,2,3,5 on 6 consecutive cycles, out_id=0, out_last only on 5, out_ovf=0. Then gnt=00 and busy=0.
- Wrap-around flag:
  - Stimulus: req=10, len1=0 (16 terms), out_ready=1.
  - Response: terms 0…233 with ovf=0. Then 121 (377 mod 256) with ovf=1, and 98 with ovf=1. out_last on 98.
- Contention and round-robin:
  - Stimulus: after reset, req=11 held, len0=len1=2.
  - Response: job order id 0,1,0,1. Each job is 0,1. There is exactly one idle cycle (out_valid=0) between jobs.
- Backpressure:
  - Stimulus: len0=4, out_ready toggling 1,0,0,1,1,0,1.
  - Response: out_data holds during ready=0 cycles. The sequence 0,1,1,2 is delivered with no loss or duplication, and out_last coincides with term 2.
- Reset mid-operation:
  - Stimulus: async rst pulse between edges during term 3 of a len=8 job.
  - Response: out_valid/gnt/busy go to 0 immediately. After release with req=10, client 1 runs a fresh job starting at 0 (rr reset to 0 does not block the sole requester).
- Request drop mid-job:
  - Stimulus: client 0 drops req after grant, len0=5.
  - Response: all 5 terms are still delivered. The next grant goes to client 1 if it is requesting.

Source files
------------

// File: rtl/fib_job_arbiter.sv
// Shares one Fibonacci term generator between two requesters: round-robin grant,
// restart from 0,1 per job, and stream the terms out over valid/ready with wrap tracking.
module fib_job_arbiter #(
   parameter int W  = 8,
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    req,
   input  logic [CW-1:0] len0,
   input  logic [CW-1:0] len1,
   output logic [1:0]    gnt,
   output logic          busy,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic          out_id,
   output logic          out_last,
   output logic          out_ovf
);

   typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

   state_t        state, state_nx;
   logic [W-1:0]  prev, curr;
   logic          prev_ovf, curr_ovf;
   logic [CW:0]   rem, rem_init;
   logic          rr, id;
   logic          grant, grant_id, step, done;
   logic [CW-1:0] len_sel;
   logic [W:0]    sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      grant    = 1'b0;
      grant_id = rr;
      step     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (req != 2'b00) begin
               grant    = 1'b1;
               grant_id = (req == 2'b11) ? rr : req[1];
               state_nx = STREAM;
            end
         end
         STREAM: begin
            if (out_ready) begin
               if (rem == (CW+1)'(1)) begin
                  done     = 1'b1;
                  state_nx = IDLE;
               end else begin
                  step = 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // A zero length field stands for the full 2^CW-term job.
   assign len_sel  = grant_id ? len1 : len0;
   assign rem_init = (len_sel == '0) ? {1'b1, {CW{1'b0}}} : {1'b0, len_sel};
   assign sum      = {1'b0, curr} + {1'b0, prev};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev     <= '0;
         curr     <= W'(1);
         prev_ovf <= 1'b0;
         curr_ovf <= 1'b0;
         rem      <= '0;
         rr       <= 1'b0;
         id       <= 1'b0;
      end else if (grant) begin
         prev     <= '0;
         curr     <= W'(1);
         prev_ovf <= 1'b0;
         curr_ovf <= 1'b0;
         rem      <= rem_init;
         id       <= grant_id;
      end else if (step) begin
         prev     <= curr;
         curr     <= sum[W-1:0];
         prev_ovf <= curr_ovf;
         curr_ovf <= sum[W] | curr_ovf | prev_ovf;
         rem      <= rem - (CW+1)'(1);
      end else if (done) begin
         rr <= ~id;
      end
   end

   // Outputs decode only registered state, so nothing leaks through from req or out_ready.
   assign busy      = (state == STREAM);
   assign out_valid = busy;
   assign gnt       = busy ? {id, ~id} : 2'b00;
   assign out_id    = busy & id;
   assign out_data  = busy ? prev : '0;
   assign out_ovf   = busy & prev_ovf;
   assign out_last  = busy && (rem == (CW+1)'(1));

endmodule
